fft_sequencer: RTL and testbench

Parametrised control sequencer for the in-place radix-2 decimation-in-time FFT datapath. For an N = 2^LOG2N point transform it generates:
- butterfly read addresses and twiddle index;
- write addresses and write enable, delayed to match the butterfly pipeline;
- ping-pong bank selection, stage number and completion handshake.

It replaces the fixed 32-point address generator and the ad-hoc memwrite delay/toggle logic around the FFT data memory. It adds a configurable size and pipeline depth, per-stage drain barriers, and an inverse-transform flag.

---
 rtl/fft_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fft_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sequencer.sv
// fft_sequencer
//   Control sequencer for an in-place radix-2 DIT FFT over N = 2^LOG2N points.
//   Issues one butterfly per cycle per stage, drains the BFU pipeline between
//   stages so every write of stage s lands before stage s+1 reads, and
//   ping-pongs the data banks each stage.
//
// Ports
//   clock          system clock, rising edge
//   ACLR           synchronous active-high reset
//   start/inverse  transform request; inverse captured with an accepted start
//   busy/done      first issue .. last write / one-cycle completion pulse
//   stage          current stage, 0 when idle
//   rd_*           butterfly read addresses and strobe
//   twiddle_*      twiddle index into N/2-entry table, conjugate flag
//   bank_read_sel  bank being read (writes go to the other bank)
//   wr_*           read strobe/addresses delayed by BFU_LATENCY cycles
//   result_bank    bank holding the finished transform
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | one butterfly read per cycle, j = 0 .. N/2-1
// DRAIN | BFU_LATENCY cycles with no reads while writes complete
// DONE  | one-cycle completion pulse
module fft_sequencer #(
    parameter int LOG2N       = 5,
    parameter int BFU_LATENCY = 9
) (
    input  logic             clock,
    input  logic             ACLR,
    input  logic             start,
    input  logic             inverse,
    output logic             busy,
    output logic             done,
    output logic [3:0]       stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_a_addr,
    output logic [LOG2N-1:0] rd_b_addr,
    output logic [LOG2N-2:0] twiddle_addr,
    output logic             twiddle_conj,
    output logic             bank_read_sel,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_a_addr,
    output logic [LOG2N-1:0] wr_b_addr,
    output logic             result_bank
);

    typedef logic [LOG2N-1:0] addr_t;
    typedef logic [LOG2N-2:0] bfly_t;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam int         PW         = 2 * LOG2N + 1;
    localparam logic [3:0] LAST_STAGE = 4'(LOG2N - 1);
    localparam logic [4:0] DRAIN_LOAD = 5'(BFU_LATENCY - 1);

    state_t          state;
    bfly_t           j;
    logic [4:0]      drain_cnt;
    logic [PW-1:0]   wr_pipe [BFU_LATENCY];

    // A = ((j >> s) << (s+1)) | (j mod 2^s); bit s of A is always zero.
    function automatic addr_t upper_addr(input logic [3:0] s, input bfly_t jv);
        addr_t jx;
        addr_t k;
        jx = addr_t'(jv);
        k  = jx & ((addr_t'(1) << s) - addr_t'(1));
        return ((jx >> s) << (s + 4'd1)) | k;
    endfunction

    // B = A + 2^s, which is an OR since bit s of A is clear.
    function automatic addr_t lower_addr(input logic [3:0] s, input bfly_t jv);
        return upper_addr(s, jv) | (addr_t'(1) << s);
    endfunction

    function automatic bfly_t twiddle_of(input logic [3:0] s, input bfly_t jv);
        addr_t k;
        addr_t t;
        k = addr_t'(jv) & ((addr_t'(1) << s) - addr_t'(1));
        t = k << (LAST_STAGE - s);
        return t[LOG2N-2:0];
    endfunction

    always_ff @(posedge clock) begin
        if (ACLR) begin
            state         <= IDLE;
            j             <= '0;
            drain_cnt     <= '0;
            stage         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rd_en         <= 1'b0;
            rd_a_addr     <= '0;
            rd_b_addr     <= '0;
            twiddle_addr  <= '0;
            twiddle_conj  <= 1'b0;
            bank_read_sel <= 1'b0;
            result_bank   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        twiddle_conj  <= inverse;
                        stage         <= '0;
                        j             <= '0;
                        bank_read_sel <= 1'b0;
                        busy          <= 1'b1;
                        rd_en         <= 1'b1;
                        rd_a_addr     <= upper_addr(4'd0, '0);
                        rd_b_addr     <= lower_addr(4'd0, '0);
                        twiddle_addr  <= twiddle_of(4'd0, '0);
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (&j) begin
                        rd_en     <= 1'b0;
                        drain_cnt <= DRAIN_LOAD;
                        state     <= DRAIN;
                    end else begin
                        j            <= j + 1'b1;
                        rd_a_addr    <= upper_addr(stage, j + 1'b1);
                        rd_b_addr    <= lower_addr(stage, j + 1'b1);
                        twiddle_addr <= twiddle_of(stage, j + 1'b1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 5'd0) begin
                        if (stage < LAST_STAGE) begin
                            stage         <= stage + 4'd1;
                            j             <= '0;
                            bank_read_sel <= ~bank_read_sel;
                            rd_en         <= 1'b1;
                            rd_a_addr     <= upper_addr(stage + 4'd1, '0);
                            rd_b_addr     <= lower_addr(stage + 4'd1, '0);
                            twiddle_addr  <= twiddle_of(stage + 4'd1, '0);
                            state         <= ISSUE;
                        end else begin
                            // The last stage wrote into the bank opposite the one it read.
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            result_bank <= ~bank_read_sel;
                            state       <= DONE;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - 5'd1;
                    end
                end
                DONE: begin
                    stage <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-side delay line; shifts every cycle so writes trail reads exactly.
    always_ff @(posedge clock) begin
        if (ACLR) begin
            for (int i = 0; i < BFU_LATENCY; i++) wr_pipe[i] <= '0;
        end else begin
            wr_pipe[0] <= {rd_en, rd_a_addr, rd_b_addr};
            for (int i = 1; i < BFU_LATENCY; i++) wr_pipe[i] <= wr_pipe[i-1];
        end
    end

    assign {wr_en, wr_a_addr, wr_b_addr} = wr_pipe[BFU_LATENCY-1];

endmodule

// File: tb/tb_fft_sequencer.sv
// Testbench for fft_sequencer: default instance (N=32, latency 9) and a small
// instance (N=8, latency 2), driven with directed scenarios.
module tb_fft_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // default instance
    logic       aclr0, start0, inverse0;
    logic       busy0, done0, rd_en0, conj0, bank0, wr_en0, rb0;
    logic [3:0] stage0;
    logic [4:0] rd_a0, rd_b0, wr_a0, wr_b0;
    logic [3:0] tw0;

    // small instance
    logic       aclr1, start1, inverse1;
    logic       busy1, done1, rd_en1, conj1, bank1, wr_en1, rb1;
    logic [3:0] stage1;
    logic [2:0] rd_a1, rd_b1, wr_a1, wr_b1;
    logic [1:0] tw1;

    fft_sequencer dut0 (
        .clock(clock), .ACLR(aclr0), .start(start0), .inverse(inverse0),
        .busy(busy0), .done(done0), .stage(stage0), .rd_en(rd_en0),
        .rd_a_addr(rd_a0), .rd_b_addr(rd_b0), .twiddle_addr(tw0),
        .twiddle_conj(conj0), .bank_read_sel(bank0), .wr_en(wr_en0),
        .wr_a_addr(wr_a0), .wr_b_addr(wr_b0), .result_bank(rb0)
    );

    fft_sequencer #(.LOG2N(3), .BFU_LATENCY(2)) dut1 (
        .clock(clock), .ACLR(aclr1), .start(start1), .inverse(inverse1),
        .busy(busy1), .done(done1), .stage(stage1), .rd_en(rd_en1),
        .rd_a_addr(rd_a1), .rd_b_addr(rd_b1), .twiddle_addr(tw1),
        .twiddle_conj(conj1), .bank_read_sel(bank1), .wr_en(wr_en1),
        .wr_a_addr(wr_a1), .wr_b_addr(wr_b1), .result_bank(rb1)
    );

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd_en;
        logic       wr_en;
        logic       bank;
        logic [3:0] stage;
        logic [9:0] a;
        logic [9:0] b;
        logic [9:0] tw;
        logic [9:0] wa;
        logic [9:0] wb;
    } exp_t;

    // Expected outputs at cycle c after a start accepted at cycle 0.
    // Butterfly j of stage s: group g = j / h, k = j % h, A = 2*h*g + k.
    function automatic exp_t model(input int log2n, input int lat, input int c);
        exp_t e;
        int   nh, p, last, s, jj, w, h;
        e    = '0;
        nh   = 1 << (log2n - 1);
        p    = nh + lat;
        last = log2n * p;
        if (c >= 1 && c <= last) begin
            e.busy  = 1'b1;
            s       = (c - 1) / p;
            jj      = (c - 1) % p;
            e.stage = 4'(s);
            e.bank  = 1'(s % 2);
            if (jj < nh) begin
                h       = 1 << s;
                e.rd_en = 1'b1;
                e.a     = 10'((jj / h) * 2 * h + jj % h);
                e.b     = 10'((jj / h) * 2 * h + jj % h + h);
                e.tw    = 10'((jj % h) * (nh / h));
            end
        end
        e.done = (c == last + 1);
        w = c - lat;
        if (w >= 1 && w <= last && ((w - 1) % p) < nh) begin
            s       = (w - 1) / p;
            jj      = (w - 1) % p;
            h       = 1 << s;
            e.wr_en = 1'b1;
            e.wa    = 10'((jj / h) * 2 * h + jj % h);
            e.wb    = 10'((jj / h) * 2 * h + jj % h + h);
        end
        return e;
    endfunction

    task automatic test_reset();
        aclr0 = 1'b1; aclr1 = 1'b1;
        start0 = 1'b0; start1 = 1'b0; inverse0 = 1'b0; inverse1 = 1'b0;
        repeat (2) @(negedge clock);
        // start arrives together with reset and must be lost
        start0 = 1'b1; start1 = 1'b1; inverse0 = 1'b1; inverse1 = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({busy0, done0, stage0, rd_en0, rd_a0, rd_b0, tw0, conj0, bank0,
             wr_en0, wr_a0, wr_b0, rb0} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_d0 got %h want 0",
                     {busy0, done0, stage0, rd_en0, rd_a0, rd_b0, tw0, conj0, bank0,
                      wr_en0, wr_a0, wr_b0, rb0});
        end
        n_checks++;
        if ({busy1, done1, stage1, rd_en1, rd_a1, rd_b1, tw1, conj1, bank1,
             wr_en1, wr_a1, wr_b1, rb1} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_d1 got %h want 0",
                     {busy1, done1, stage1, rd_en1, rd_a1, rd_b1, tw1, conj1, bank1,
                      wr_en1, wr_a1, wr_b1, rb1});
        end
        aclr0 = 1'b0; aclr1 = 1'b0;
        start0 = 1'b0; start1 = 1'b0; inverse0 = 1'b0; inverse1 = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({busy0, rd_en0, conj0} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_beats_start_d0 got %b want 000", {busy0, rd_en0, conj0});
        end
        n_checks++;
        if ({busy1, rd_en1, conj1} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_beats_start_d1 got %b want 000", {busy1, rd_en1, conj1});
        end
    endtask

    // Full default-size transform; inverse toggles every cycle after start,
    // optional re-start pulses at cycle 50 (busy) and 126 (done cycle).
    task automatic test_full_run(input string tag, input bit inv, input bit pokes);
        exp_t e;
        @(negedge clock);
        start0   = 1'b1;
        inverse0 = inv;
        for (int c = 1; c <= 130; c++) begin
            @(negedge clock);
            start0   = pokes && (c == 50 || c == 126);
            inverse0 = ~inverse0;
            e = model(5, 9, c);
            n_checks++;
            if (busy0 !== e.busy) begin
                n_fail++;
                $display("FAIL %s busy c=%0d got %b want %b", tag, c, busy0, e.busy);
            end
            n_checks++;
            if (done0 !== e.done) begin
                n_fail++;
                $display("FAIL %s done c=%0d got %b want %b", tag, c, done0, e.done);
            end
            n_checks++;
            if (rd_en0 !== e.rd_en) begin
                n_fail++;
                $display("FAIL %s rd_en c=%0d got %b want %b", tag, c, rd_en0, e.rd_en);
            end
            n_checks++;
            if (wr_en0 !== e.wr_en) begin
                n_fail++;
                $display("FAIL %s wr_en c=%0d got %b want %b", tag, c, wr_en0, e.wr_en);
            end
            if (e.rd_en) begin
                n_checks++;
                if ({rd_a0, rd_b0, tw0} !== {e.a[4:0], e.b[4:0], e.tw[3:0]}) begin
                    n_fail++;
                    $display("FAIL %s rd_addr c=%0d got a=%0d b=%0d tw=%0d want a=%0d b=%0d tw=%0d",
                             tag, c, rd_a0, rd_b0, tw0, e.a, e.b, e.tw);
                end
            end
            if (e.wr_en) begin
                n_checks++;
                if ({wr_a0, wr_b0} !== {e.wa[4:0], e.wb[4:0]}) begin
                    n_fail++;
                    $display("FAIL %s wr_addr c=%0d got a=%0d b=%0d want a=%0d b=%0d",
                             tag, c, wr_a0, wr_b0, e.wa, e.wb);
                end
            end
            if (e.busy) begin
                n_checks++;
                if ({stage0, bank0} !== {e.stage, e.bank}) begin
                    n_fail++;
                    $display("FAIL %s stage_bank c=%0d got %0d/%b want %0d/%b",
                             tag, c, stage0, bank0, e.stage, e.bank);
                end
            end
            if (c >= 127) begin
                n_checks++;
                if (stage0 !== 4'd0) begin
                    n_fail++;
                    $display("FAIL %s idle_stage c=%0d got %0d want 0", tag, c, stage0);
                end
            end
            n_checks++;
            if (conj0 !== inv) begin
                n_fail++;
                $display("FAIL %s twiddle_conj c=%0d got %b want %b", tag, c, conj0, inv);
            end
            if (c >= 126) begin
                n_checks++;
                if (rb0 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s result_bank c=%0d got %b want 1", tag, c, rb0);
                end
            end
            if (c == 4) begin
                n_checks++;
                if ({rd_a0, rd_b0, tw0} !== {5'd6, 5'd7, 4'd0}) begin
                    n_fail++;
                    $display("FAIL %s s0_j3 got a=%0d b=%0d tw=%0d want 6 7 0", tag, rd_a0, rd_b0, tw0);
                end
            end
            if (c == 31) begin
                n_checks++;
                if ({rd_a0, rd_b0, tw0} !== {5'd9, 5'd11, 4'd8}) begin
                    n_fail++;
                    $display("FAIL %s s1_j5 got a=%0d b=%0d tw=%0d want 9 11 8", tag, rd_a0, rd_b0, tw0);
                end
            end
            if (c == 106) begin
                n_checks++;
                if ({rd_a0, rd_b0, tw0} !== {5'd5, 5'd21, 4'd5}) begin
                    n_fail++;
                    $display("FAIL %s s4_j5 got a=%0d b=%0d tw=%0d want 5 21 5", tag, rd_a0, rd_b0, tw0);
                end
            end
        end
        start0 = 1'b0;
    endtask

    task automatic test_small();
        exp_t       e;
        logic [22:0] rd_pat;
        logic [22:0] wr_pat;
        rd_pat = 23'b00000011110011110011110;
        wr_pat = 23'b00001111001111001111000;
        @(negedge clock);
        start1   = 1'b1;
        inverse1 = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clock);
            start1 = 1'b0;
            e = model(3, 2, c);
            n_checks++;
            if (rd_en1 !== rd_pat[c]) begin
                n_fail++;
                $display("FAIL small rd_en c=%0d got %b want %b", c, rd_en1, rd_pat[c]);
            end
            n_checks++;
            if (wr_en1 !== wr_pat[c]) begin
                n_fail++;
                $display("FAIL small wr_en c=%0d got %b want %b", c, wr_en1, wr_pat[c]);
            end
            n_checks++;
            if ({busy1, done1} !== {(c >= 1 && c <= 18), (c == 19)}) begin
                n_fail++;
                $display("FAIL small busy_done c=%0d got %b%b want %b%b", c, busy1, done1,
                         (c >= 1 && c <= 18), (c == 19));
            end
            if (c <= 18) begin
                n_checks++;
                if (bank1 !== (c >= 7 && c <= 12)) begin
                    n_fail++;
                    $display("FAIL small bank c=%0d got %b want %b", c, bank1, (c >= 7 && c <= 12));
                end
            end
            if (rd_pat[c]) begin
                n_checks++;
                if ({rd_a1, rd_b1, tw1} !== {e.a[2:0], e.b[2:0], e.tw[1:0]}) begin
                    n_fail++;
                    $display("FAIL small rd_addr c=%0d got a=%0d b=%0d tw=%0d want a=%0d b=%0d tw=%0d",
                             c, rd_a1, rd_b1, tw1, e.a, e.b, e.tw);
                end
            end
            if (wr_pat[c]) begin
                n_checks++;
                if ({wr_a1, wr_b1} !== {e.wa[2:0], e.wb[2:0]}) begin
                    n_fail++;
                    $display("FAIL small wr_addr c=%0d got a=%0d b=%0d want a=%0d b=%0d",
                             c, wr_a1, wr_b1, e.wa, e.wb);
                end
            end
            if (c >= 19) begin
                n_checks++;
                if (rb1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL small result_bank c=%0d got %b want 1", c, rb1);
                end
            end
        end
    endtask

    // Reset at cycle 40 of an inverse run, then restart at cycle 45.
    task automatic test_abort();
        @(negedge clock);
        start0   = 1'b1;
        inverse0 = 1'b1;
        for (int c = 1; c <= 173; c++) begin
            @(negedge clock);
            if (c == 40) begin
                n_checks++;
                if (busy0 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL abort busy_before c=40 got %b want 1", busy0);
                end
            end
            if (c == 41) begin
                n_checks++;
                if ({busy0, done0, stage0, rd_en0, rd_a0, rd_b0, tw0, conj0, bank0,
                     wr_en0, wr_a0, wr_b0, rb0} !== '0) begin
                    n_fail++;
                    $display("FAIL abort outputs c=41 got %h want 0",
                             {busy0, done0, stage0, rd_en0, rd_a0, rd_b0, tw0, conj0, bank0,
                              wr_en0, wr_a0, wr_b0, rb0});
                end
            end
            if (c >= 41 && c <= 54) begin
                n_checks++;
                if (wr_en0 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort stale_wr c=%0d got %b want 0", c, wr_en0);
                end
            end
            if (c >= 42 && c <= 45) begin
                n_checks++;
                if ({busy0, rd_en0} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL abort idle c=%0d got %b want 00", c, {busy0, rd_en0});
                end
            end
            if (c == 46) begin
                n_checks++;
                if ({rd_en0, busy0, bank0, rd_a0, rd_b0} !== {1'b1, 1'b1, 1'b0, 5'd0, 5'd1}) begin
                    n_fail++;
                    $display("FAIL abort restart c=46 got en=%b busy=%b bank=%b a=%0d b=%0d want 1 1 0 0 1",
                             rd_en0, busy0, bank0, rd_a0, rd_b0);
                end
            end
            if (c >= 46) begin
                n_checks++;
                if (done0 !== (c == 171)) begin
                    n_fail++;
                    $display("FAIL abort done c=%0d got %b want %b", c, done0, (c == 171));
                end
            end
            aclr0  = (c == 40);
            start0 = (c == 45);
            if (c == 45) inverse0 = 1'b0;
        end
        start0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_run("inverse", 1'b1, 1'b0);
        test_full_run("forward", 1'b0, 1'b1);
        test_small();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
